// File: rtl/hworld_init_pkg.sv
// hworld_init_pkg: register offsets and job sequencer states for the hworld OBI initiator
package hworld_init_pkg;

  localparam logic [31:0] A_OFFSET    = 32'h0;
  localparam logic [31:0] B_OFFSET    = 32'h4;
  localparam logic [31:0] SUM_OFFSET  = 32'h8;
  localparam logic [31:0] COUT_OFFSET = 32'hC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_RB_A,
    S_RB_B,
    S_RD_SUM,
    S_RD_COUT,
    S_DONE
  } init_state_e;

endpackage

// File: rtl/obi_pkg.sv
// obi_pkg: OBI request/response field bundles shared by managers and subordinates
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/hworld_obi_txn.sv
// hworld_obi_txn: single OBI transaction engine (REQ phase until gnt, RSP phase until rvalid)
//   clk_i, rst_ni   clock, async active-low reset
//   start_i         load addr/we/wdata and raise req next cycle
//   obi_req_o       registered request; all fields 0 while req is 0
//   obi_rsp_i       gnt / rvalid / rdata from the subordinate
//   done_o          rvalid accepted in RSP phase (combinational pulse)
//   rdata_o         response data, valid with done_o
module hworld_obi_txn
  import obi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output obi_req_t    obi_req_o,
  input  obi_resp_t   obi_rsp_i,
  output logic        done_o,
  output logic [31:0] rdata_o
);

  logic        r_req;
  logic        r_rsp;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  assign done_o  = r_rsp && obi_rsp_i.rvalid;
  assign rdata_o = obi_rsp_i.rdata;

  assign obi_req_o.req   = r_req;
  assign obi_req_o.addr  = r_addr;
  assign obi_req_o.we    = r_we;
  assign obi_req_o.be    = {4{r_req}};
  assign obi_req_o.wdata = r_wdata;

  // start may coincide with done of the previous transaction; it wins and clears RSP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req   <= 1'b0;
      r_rsp   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (start_i) begin
      r_req   <= 1'b1;
      r_rsp   <= 1'b0;
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
    end else if (r_req && obi_rsp_i.gnt) begin
      r_req   <= 1'b0;
      r_rsp   <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (done_o) begin
      r_rsp   <= 1'b0;
    end
  end

endmodule

// File: rtl/hworld_obi_initiator.sv
// hworld_obi_initiator: runs one hworld add job (write A/B, read SUM/COUT) over OBI per command
//   clk_i, rst_ni                     clock, async active-low reset
//   start_valid_i/start_ready_o, a_i, b_i   command port
//   res_valid_o/res_ready_i, sum_o, cout_o, err_o   result port
//   busy_o                            high outside IDLE
//   obi_req_o / obi_rsp_i             OBI manager port
//   HWORLD_INIT_VERIFY_EN             adds A/B readback and err_o reporting
module hworld_obi_initiator
  import obi_pkg::*;
  import hworld_init_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_valid_i,
  output logic        start_ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] sum_o,
  output logic        cout_o,
  output logic        err_o,
  output logic        busy_o,
  output obi_req_t    obi_req_o,
  input  obi_resp_t   obi_rsp_i
);

`ifdef HWORLD_INIT_VERIFY_EN
  localparam init_state_e AFTER_B = S_RB_A;
`else
  localparam init_state_e AFTER_B = S_RD_SUM;
`endif

  init_state_e r_state;
  init_state_e w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_sum;
  logic        r_cout;
  logic        r_ready;
  logic        r_busy;
  logic        r_res_valid;
  logic        w_cmd;
  logic        w_start;
  logic        w_done;
  logic        w_we;
  logic [31:0] w_off;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = start_valid_i ? S_WR_A : S_IDLE;
      S_WR_A:    w_next = w_done ? S_WR_B : S_WR_A;
      S_WR_B:    w_next = w_done ? AFTER_B : S_WR_B;
      S_RB_A:    w_next = w_done ? S_RB_B : S_RB_A;
      S_RB_B:    w_next = w_done ? S_RD_SUM : S_RB_B;
      S_RD_SUM:  w_next = w_done ? S_RD_COUT : S_RD_SUM;
      S_RD_COUT: w_next = w_done ? S_DONE : S_RD_COUT;
      S_DONE:    w_next = res_ready_i ? S_IDLE : S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end

  // the next transaction is issued in the cycle its predecessor completes, so req rises one cycle later
  assign w_cmd   = start_valid_i && r_state == S_IDLE;
  assign w_start = w_next != r_state && w_next != S_IDLE && w_next != S_DONE;
  assign w_we    = w_next == S_WR_A || w_next == S_WR_B;
  assign w_off   = (w_next == S_WR_A || w_next == S_RB_A) ? A_OFFSET :
                   (w_next == S_WR_B || w_next == S_RB_B) ? B_OFFSET :
                   w_next == S_RD_SUM ? SUM_OFFSET : COUT_OFFSET;
  // A is written straight from the command port since it is latched on the same edge
  assign w_wdata = w_next == S_WR_A ? (w_cmd ? a_i : r_a) :
                   w_next == S_WR_B ? r_b : '0;

  hworld_obi_txn u_txn (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (w_start),
    .addr_i    (BASE_ADDR + w_off),
    .we_i      (w_we),
    .wdata_i   (w_wdata),
    .obi_req_o (obi_req_o),
    .obi_rsp_i (obi_rsp_i),
    .done_o    (w_done),
    .rdata_o   (w_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ready     <= w_next == S_IDLE;
      r_busy      <= w_next != S_IDLE;
      r_res_valid <= w_next == S_DONE;
      if (w_cmd) begin
        r_a <= a_i;
        r_b <= b_i;
      end
      if (w_done && r_state == S_RD_SUM) r_sum <= w_rdata;
      if (w_done && r_state == S_RD_COUT) r_cout <= w_rdata[0];
    end
  end

`ifdef HWORLD_INIT_VERIFY_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err <= 1'b0;
    else if (w_cmd) r_err <= 1'b0;
    else if (w_done && ((r_state == S_RB_A && w_rdata != r_a) || (r_state == S_RB_B && w_rdata != r_b))) r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign start_ready_o = r_ready;
  assign busy_o        = r_busy;
  assign res_valid_o   = r_res_valid;
  assign sum_o         = r_sum;
  assign cout_o        = r_cout;

endmodule

// File: tb/tb_hworld_obi_initiator.sv
// tb_hworld_obi_initiator: directed jobs against a negedge-driven hworld OBI responder model
module tb_hworld_obi_initiator;
  import obi_pkg::*;

`ifdef HWORLD_INIT_VERIFY_EN
  localparam int NT = 6;
  localparam int LAT0 = 13;
  localparam logic [31:0] EMASK = 32'h0000_0AAA;
`else
  localparam int NT = 4;
  localparam int LAT0 = 9;
  localparam logic [31:0] EMASK = 32'h0000_00AA;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        err;
  logic        busy;
  obi_req_t    oreq;
  obi_resp_t   orsp = '0;

  always #5 clk = ~clk;

  hworld_obi_initiator dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_valid_i (start_valid),
    .start_ready_o (start_ready),
    .a_i           (a),
    .b_i           (b),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .sum_o         (sum),
    .cout_o        (cout),
    .err_o         (err),
    .busy_o        (busy),
    .obi_req_o     (oreq),
    .obi_rsp_i     (orsp)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // responder: hworld register file with programmable grant delay and fault knobs
  int          gnt_dly = 0;
  int          gwait = 0;
  int          pidx = 0;
  int          n_unstable = 0;
  logic        pend = 1'b0;
  logic        holding = 1'b0;
  logic        corrupt_b = 1'b0;
  logic        hold_sum = 1'b0;
  logic        spur = 1'b0;
  logic [31:0] pdata = '0;
  logic [32:0] full = '0;
  logic [31:0] mem [4];
  obi_req_t    held;
  logic [31:0] log_addr [$];
  logic [31:0] log_wd [$];
  logic [4:0]  log_webe [$];
  logic [31:0] mask = '0;

  always @(negedge clk) begin
    orsp = '0;
    if (!rst_n) begin
      pend = 1'b0;
      gwait = 0;
      holding = 1'b0;
    end else begin
      if (pend && !(hold_sum && pidx == 2)) begin
        orsp.rvalid = 1'b1;
        orsp.rdata = pdata;
        pend = 1'b0;
      end
      if (oreq.req) begin
        if (holding && oreq != held) n_unstable++;
        held = oreq;
        holding = 1'b1;
        if (gwait < gnt_dly) gwait++;
        else begin
          orsp.gnt = 1'b1;
          gwait = 0;
          holding = 1'b0;
          log_addr.push_back(oreq.addr);
          log_wd.push_back(oreq.wdata);
          log_webe.push_back({oreq.we, oreq.be});
          pidx = int'(oreq.addr[3:2]);
          full = {1'b0, mem[0]} + {1'b0, mem[1]};
          if (oreq.we) begin
            mem[pidx] = oreq.wdata;
            pdata = '0;
          end else begin
            pdata = pidx == 0 ? mem[0] : pidx == 1 ? (corrupt_b ? 32'h8 : mem[1]) :
                    pidx == 2 ? full[31:0] : {31'b0, full[32]};
          end
          pend = 1'b1;
        end
      end
      if (spur) begin
        orsp.rvalid = 1'b1;
        orsp.rdata = 32'hDEAD_BEEF;
        orsp.gnt = 1'b1;
      end
    end
  end

  task automatic job(input string t, input logic [31:0] ja, input logic [31:0] jb, input int hold,
                     input logic [31:0] esum, input logic ecout, input logic eerr, input int elat);
    int cnt;
    log_addr.delete();
    log_wd.delete();
    log_webe.delete();
    mask = '0;
    a = ja;
    b = jb;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = ~ja;
    b = ~jb;
    cnt = 1;
    mask[1] = oreq.req;
    while (!res_valid && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt < 32) mask[cnt] = oreq.req;
    end
    chk({t, " latency"}, cnt, elat);
    chk({t, " sum"}, sum, esum);
    chk({t, " cout"}, {31'b0, cout}, {31'b0, ecout});
    chk({t, " err"}, {31'b0, err}, {31'b0, eerr});
    chk({t, " ready in done"}, {31'b0, start_ready}, 0);
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      chk({t, " hold valid"}, {31'b0, res_valid}, 1);
      chk({t, " hold sum"}, sum, esum);
      chk({t, " hold cout"}, {31'b0, cout}, {31'b0, ecout});
      chk({t, " hold ready"}, {31'b0, start_ready}, 0);
      chk({t, " hold req"}, {31'b0, oreq.req}, 0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk({t, " post valid"}, {31'b0, res_valid}, 0);
    chk({t, " post ready"}, {31'b0, start_ready}, 1);
    chk({t, " post busy"}, {31'b0, busy}, 0);
  endtask

  logic [31:0] ea [$];
  logic [31:0] ew [$];
  logic [4:0]  eb [$];

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", {31'b0, start_ready}, 1);
    chk("rst valid", {31'b0, res_valid}, 0);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst sum", sum, 0);
    chk("rst cout/err", {30'b0, cout, err}, 0);
    chk("rst req", {31'b0, oreq.req}, 0);
    chk("rst addr", oreq.addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    job("zw", 32'h5, 32'h7, 0, 32'hC, 1'b0, 1'b0, LAT0);
    chk("zw req mask", mask, EMASK);
`ifdef HWORLD_INIT_VERIFY_EN
    ea = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h8, 32'hC};
    ew = '{32'h5, 32'h7, 32'h0, 32'h0, 32'h0, 32'h0};
    eb = '{5'h1F, 5'h1F, 5'h0F, 5'h0F, 5'h0F, 5'h0F};
`else
    ea = '{32'h0, 32'h4, 32'h8, 32'hC};
    ew = '{32'h5, 32'h7, 32'h0, 32'h0};
    eb = '{5'h1F, 5'h1F, 5'h0F, 5'h0F};
`endif
    chk("zw ntxn", log_addr.size(), NT);
    for (int i = 0; i < NT && i < log_addr.size(); i++) begin
      chk($sformatf("zw addr%0d", i), log_addr[i], ea[i]);
      chk($sformatf("zw wdata%0d", i), log_wd[i], ew[i]);
      chk($sformatf("zw we_be%0d", i), {27'b0, log_webe[i]}, {27'b0, eb[i]});
    end

    gnt_dly = 3;
    n_unstable = 0;
    job("gd3", 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1'b1, 1'b0, LAT0 + 3 * NT);
    chk("gd3 stable", n_unstable, 0);
    chk("gd3 ntxn", log_addr.size(), NT);
    gnt_dly = 0;

    job("hold", 32'h1234_5678, 32'h1111_1111, 5, 32'h2345_6789, 1'b0, 1'b0, LAT0);

    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("spur busy", {31'b0, busy}, 0);
      chk("spur req", {31'b0, oreq.req}, 0);
      chk("spur sum", sum, 32'h2345_6789);
    end
    spur = 1'b0;
    @(posedge clk);
    #1;

    job("carry", 32'h8000_0001, 32'h8000_0000, 0, 32'h1, 1'b1, 1'b0, LAT0);

    hold_sum = 1'b1;
    log_addr.delete();
    a = 32'h3;
    b = 32'h4;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    cnt = 0;
    while (log_addr.size() < NT - 1 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("rstmid reached sum", log_addr.size(), NT - 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid busy", {31'b0, busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid req", {31'b0, oreq.req}, 0);
    chk("rstmid busy0", {31'b0, busy}, 0);
    chk("rstmid ready", {31'b0, start_ready}, 1);
    chk("rstmid sum", sum, 0);
    chk("rstmid cout", {31'b0, cout}, 0);
    @(negedge clk);
    #1;
    hold_sum = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    job("after rst", 32'h0000_0100, 32'h0000_0023, 0, 32'h123, 1'b0, 1'b0, LAT0);

`ifdef HWORLD_INIT_VERIFY_EN
    corrupt_b = 1'b1;
    job("verify bad", 32'h5, 32'h7, 0, 32'hC, 1'b0, 1'b1, LAT0);
    corrupt_b = 1'b0;
    job("verify clr", 32'h5, 32'h7, 0, 32'hC, 1'b0, 1'b0, LAT0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
